// File: rtl/priority_encoder.sv
// Registered highest-bit-first priority encoder with valid flag, one cycle latency.
// Optional registered one-hot output enabled by defining PRIORITY_ENCODER_ONEHOT_EN.
module priority_encoder #(
   parameter  int WIDTH = 8,
   localparam int OUT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output logic [OUT_W-1:0] out,
   output logic             valid
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   ,
   output logic [WIDTH-1:0] onehot
`endif
);

   localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [OUT_W-1:0] idx_s;
   logic             any_s;
   logic [OUT_W-1:0] out_r;
   logic             valid_r;

   // Ascending scan: a later (higher) set bit overwrites any lower one.
   always_comb begin
      idx_s = {OUT_W{1'b0}};
      any_s = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         idx_s = in[i] ? OUT_W'(i) : idx_s;
         any_s = any_s | in[i];
      end
   end

   // Single output register stage; hold when en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r   <= {OUT_W{1'b0}};
         valid_r <= 1'b0;
      end else if (en) begin
         out_r   <= idx_s;
         valid_r <= any_s;
      end
   end

   assign out   = out_r;
   assign valid = valid_r;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [WIDTH-1:0] onehot_s;
   logic [WIDTH-1:0] onehot_r;

   // One-hot form of the winner, zero when nothing is requested.
   always_comb begin
      onehot_s = {WIDTH{1'b0}};
      if (any_s) begin
         onehot_s = ONE_W << idx_s;
      end else begin
         onehot_s = {WIDTH{1'b0}};
      end
   end

   // Shares reset and enable behaviour with out/valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         onehot_r <= {WIDTH{1'b0}};
      end else if (en) begin
         onehot_r <= onehot_s;
      end
   end

   assign onehot = onehot_r;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and random checks of priority_encoder at WIDTH=8 and WIDTH=5 against an arithmetic model.
module tb_priority_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en;
   logic [7:0] in8;
   logic [4:0] in5;
   logic [2:0] out8;
   logic [2:0] out5;
   logic       valid8;
   logic       valid5;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [7:0] oh8;
   logic [4:0] oh5;
`endif

   int tests = 0;
   int fails = 0;
   int m8_out = 0, m8_valid = 0, m5_out = 0, m5_valid = 0;

   priority_encoder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in8), .out(out8), .valid(valid8)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      , .onehot(oh8)
`endif
   );

   priority_encoder #(.WIDTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .en(en), .in(in5), .out(out5), .valid(valid5)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      , .onehot(oh5)
`endif
   );

   // floor(log2(v)) for v>0: position of the most significant one.
   function automatic int hb(input int v);
      int r = 0;
      if (v == 0) return 0;
      while (v > 1) begin
         v = v >> 1;
         r++;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: result of the request seen at each enabled edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m8_out <= 0; m8_valid <= 0; m5_out <= 0; m5_valid <= 0;
      end else if (en) begin
         m8_out   <= hb(int'(in8));
         m8_valid <= (in8 != 8'd0) ? 1 : 0;
         m5_out   <= hb(int'(in5));
         m5_valid <= (in5 != 5'd0) ? 1 : 0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      chk("cyc_out8", int'(out8), m8_out);
      chk("cyc_valid8", int'(valid8), m8_valid);
      chk("cyc_out5", int'(out5), m5_out);
      chk("cyc_valid5", int'(valid5), m5_valid);
      chk("out5_range", (int'(out5) < 5) ? 1 : 0, 1);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      chk("cyc_oh8", int'(oh8), m8_valid ? (1 << m8_out) : 0);
      chk("cyc_oh5", int'(oh5), m5_valid ? (1 << m5_out) : 0);
`endif
   end

   task automatic step8(input logic [7:0] v, input int eo, input int ev, input string nm);
      @(negedge clk);
      in8 = v;
      @(posedge clk);
      #1;
      chk({nm, "_out"}, int'(out8), eo);
      chk({nm, "_valid"}, int'(valid8), ev);
   endtask

   task automatic step5(input logic [4:0] v, input int eo, input int ev, input string nm);
      @(negedge clk);
      in5 = v;
      @(posedge clk);
      #1;
      chk({nm, "_out"}, int'(out5), eo);
      chk({nm, "_valid"}, int'(valid5), ev);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      in8   = 8'h00;
      in5   = 5'd0;
      #1;
      chk("rst_out", int'(out8), 0);
      chk("rst_valid", int'(valid8), 0);
      @(negedge clk);
      rst_n = 1'b1;

      step8(8'h00, 0, 0, "zero");
      step8(8'h01, 0, 1, "bit0");
      step8(8'h08, 3, 1, "bit3");
      step8(8'h80, 7, 1, "bit7");
      step8(8'b1000_1001, 7, 1, "multi89");
      step8(8'b0110_0000, 6, 1, "multi60");
      step8(8'b0000_0110, 2, 1, "multi06");

      step8(8'h20, 5, 1, "cap20");
      en = 1'b0;
      for (int k = 0; k < 3; k++) step8(8'h80, 5, 1, "hold");
      en = 1'b1;
      step8(8'h80, 7, 1, "resume");

      step8(8'h0C, 3, 1, "oh0c");
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      chk("oh0c_onehot", int'(oh8), 8);
`endif
      step8(8'h00, 0, 0, "oh00");
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      chk("oh00_onehot", int'(oh8), 0);
`endif

      // Asynchronous reset in the middle of a cycle with a pending capture.
      step8(8'h08, 3, 1, "prerst");
      @(negedge clk);
      in8 = 8'hFF;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out", int'(out8), 0);
      chk("async_valid", int'(valid8), 0);
      @(posedge clk);
      #1;
      chk("held_out", int'(out8), 0);
      chk("held_valid", int'(valid8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out", int'(out8), 7);
      chk("release_valid", int'(valid8), 1);

      step5(5'b10000, 4, 1, "w5_top");
      step5(5'b00011, 1, 1, "w5_low");
      step5(5'b00000, 0, 0, "w5_zero");
      step5(5'b11111, 4, 1, "w5_all");
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         in5 = 5'($urandom_range(0, 31));
         in8 = 8'($urandom_range(0, 255));
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Parameterised, registered highest-bit-first priority encoder with an explicit valid flag.
- Converts a WIDTH-bit request vector into the binary index of its most-significant set bit.
- Used wherever one of several requesters must be selected by fixed priority, for example interrupt or request selection in front of arbitration or muxing logic.
- Single clock domain; output is registered, so latency is one cycle.

Parameters:
- WIDTH, 8, number of request inputs; legal range 2 to 256, power of two not required.
- OUT_W, $clog2(WIDTH), width of the encoded index. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; output registers update only when high
- in  input  WIDTH  request vector; bit i high means requester i is active
- out  output  OUT_W  index of the highest-numbered set bit in `in`, registered
- valid  output  1  registered; high when the captured `in` had at least one bit set

Behaviour:
- Reset:
  - rst_n low forces out=0 and valid=0 immediately, without waiting for a clock edge.
  - Outputs stay there while rst_n is low.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Priority: the highest index wins.
  - out = i, where i is the largest index with in[i]=1; all lower bits are ignored.
  - Examples for WIDTH=8: 8'b0000_0001 -> 0; 8'b0000_1000 -> 3; 8'b1000_0000 -> 7; 8'b1000_1001 -> 7.
- Zero input: in==0 -> out=0 and valid=0. An index of 0 is therefore distinguished only by valid.
- Latency:
  - Exactly one cycle.
  - The value of `in` sampled on rising edge N appears on out/valid after edge N (no combinational path from `in` to the outputs).
  - Back-to-back changes on consecutive cycles each produce their own result.
- Enable: en=0 at a rising edge -> out and valid hold their previous values; `in` is ignored.
- Reset mid-operation: an asynchronous rst_n assertion overrides everything and clears both outputs in the same instant. A capture pending on the next edge is discarded.
- Width rules:
  - Index bits above what WIDTH needs are never set, so out < WIDTH always.
  - For non-power-of-two WIDTH, unused codes (WIDTH..2^OUT_W-1) never appear.
- X handling: inputs carry no X/Z requirement; no X may propagate to the outputs after reset.
- Implementation: the priority search must be a fully combinational scan/tree feeding one register stage. No multicycle paths.

Optional Feature:
- Macro: PRIORITY_ENCODER_ONEHOT_EN.
- Defined: adds output port `onehot` (WIDTH bits, registered with the same latency, enable and reset as out).
  - Has exactly bit `out` set when valid=1; all zeros when valid=0.
  - Reset value is all zeros.
- Undefined: port `onehot` and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with in=8'hFF, en=1 -> out=0 and valid=0 immediately; after release, the first edge gives out=7, valid=1.
- Zero and single bits (en=1): in=8'h00 -> out=0, valid=0. in=8'h01 -> out=0, valid=1. in=8'h08 -> out=3, valid=1. in=8'h80 -> out=7, valid=1. Each result appears one edge after it is applied.
- Priority with multiple bits: in=8'b1000_1001 -> out=7. in=8'b0110_0000 -> out=6. in=8'b0000_0110 -> out=2. All valid=1.
- Enable hold: capture in=8'h20 (out=5), then set en=0 and in=8'h80 for 3 cycles -> out stays 5; set en=1 -> next edge gives out=7.
- Non-power-of-two width (WIDTH=5, OUT_W=3): in=5'b10000 -> out=4. in=5'b00011 -> out=1. Random sweep -> out<5 always.
- With PRIORITY_ENCODER_ONEHOT_EN defined: in=8'h0C -> out=3, onehot=8'h08. in=0 -> onehot=8'h00, valid=0.
